// File: rtl/dac_wave_player.sv
// Multi-channel waveform playback engine: per-channel block-RAM banks loaded by the CPU,
// played in lockstep at a programmable rate through a valid/ready handshake to the DAC.
module dac_wave_player #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 11,
   parameter int NUM_CH     = 2,
   parameter int DIV_WIDTH  = 16,
   localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                         clk,
   input  logic                         arst_n,
   input  logic                         cpu_we,
   input  logic                         cpu_re,
   input  logic [CH_W-1:0]              cpu_ch,
   input  logic [ADDR_WIDTH-1:0]        cpu_addr,
   input  logic [DATA_WIDTH-1:0]        cpu_wdata,
   output logic [DATA_WIDTH-1:0]        cpu_rdata,
   output logic                         cpu_rvalid,
   input  logic [ADDR_WIDTH-1:0]        cfg_len,
   input  logic [DIV_WIDTH-1:0]         cfg_div,
   input  logic                         cfg_oneshot,
   input  logic                         start,
   input  logic                         stop,
   output logic                         busy,
   output logic                         done,
   output logic                         overrun,
   output logic [NUM_CH*DATA_WIDTH-1:0] dac_data,
   output logic                         dac_valid,
   input  logic                         dac_ready
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   len_q, ptr_q, ptr_nxt, rd_addr;
   logic [DIV_WIDTH-1:0]    div_q, cnt_q;
   logic                    oneshot_q;
   logic                    accept, tick, rd_en, done_d, abort, hs;
   logic                    rd_ok_q;
   logic [CH_W-1:0]         ch_q;
   logic [NUM_CH*DATA_WIDTH-1:0] a_all, b_all;

   assign hs      = dac_valid && dac_ready;
   assign abort   = stop && (state_q != IDLE);
   assign ptr_nxt = (ptr_q == len_q) ? '0 : ptr_q + 1'b1;
   assign busy    = (state_q != IDLE);

   // Port A serves the CPU (read-first); port B only reads the word for the next sample.
   for (genvar c = 0; c < NUM_CH; c++) begin : g_bank
      (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
      logic [DATA_WIDTH-1:0] a_q, b_q;
      logic                  a_sel;

      assign a_sel = (cpu_ch == CH_W'(c));

      // NOTE: RAM arrays and their output registers have no reset so they map onto block RAM.
      always_ff @(posedge clk) begin
         if (cpu_re && a_sel) a_q <= mem[cpu_addr];
         if (cpu_we && a_sel) mem[cpu_addr] <= cpu_wdata;
      end

      always_ff @(posedge clk) begin
         if (rd_en) b_q <= mem[rd_addr];
      end

      assign a_all[c*DATA_WIDTH +: DATA_WIDTH] = a_q;
      assign b_all[c*DATA_WIDTH +: DATA_WIDTH] = b_q;
   end

   // Readback stays zero until a read of an existing bank completes.
   always_comb begin
      cpu_rdata = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (rd_ok_q && int'(ch_q) == c) cpu_rdata = a_all[c*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      tick    = 1'b0;
      rd_en   = 1'b0;
      rd_addr = ptr_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !stop) begin
               accept  = 1'b1;
               state_d = PRIME;
            end
         end
         PRIME: begin
            rd_en   = 1'b1;
            state_d = RUN;
         end
         RUN: begin
            if (cnt_q == '0) begin
               tick = 1'b1;
               if (oneshot_q && ptr_q == len_q) begin
                  state_d = DRAIN;
               end else begin
                  rd_en   = 1'b1;
                  rd_addr = ptr_nxt;
               end
            end
         end
         DRAIN: begin
            if (hs) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (abort) begin
         state_d = IDLE;
         tick    = 1'b0;
         rd_en   = 1'b0;
         done_d  = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q    <= IDLE;
         len_q      <= '0;
         div_q      <= '0;
         oneshot_q  <= 1'b0;
         ptr_q      <= '0;
         cnt_q      <= '0;
         done       <= 1'b0;
         overrun    <= 1'b0;
         dac_valid  <= 1'b0;
         dac_data   <= '0;
         cpu_rvalid <= 1'b0;
         rd_ok_q    <= 1'b0;
         ch_q       <= '0;
      end else begin
         state_q    <= state_d;
         done       <= done_d;
         cpu_rvalid <= cpu_re;
         if (cpu_re) begin
            ch_q    <= cpu_ch;
            rd_ok_q <= (int'(cpu_ch) < NUM_CH);
         end

         if (accept) begin
            len_q     <= cfg_len;
            div_q     <= cfg_div;
            oneshot_q <= cfg_oneshot;
            ptr_q     <= '0;
            cnt_q     <= '0;
            overrun   <= 1'b0;
         end else if (state_q == RUN && !abort) begin
            if (tick) begin
               cnt_q <= div_q;
               ptr_q <= ptr_nxt;
            end else begin
               cnt_q <= cnt_q - 1'b1;
            end
         end

         // A new sample replaces an unaccepted one and flags the loss.
         if (abort) begin
            dac_valid <= 1'b0;
         end else if (tick) begin
            dac_data  <= b_all;
            dac_valid <= 1'b1;
            if (dac_valid && !dac_ready) overrun <= 1'b1;
         end else if (hs) begin
            dac_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dac_wave_player.sv
// Directed bench for dac_wave_player: CPU load/readback, loop and one-shot playback,
// backpressure, abort and asynchronous reset, with a sample scoreboard.
module tb_dac_wave_player;

   localparam int DW  = 16;
   localparam int AW  = 11;
   localparam int NCH = 3;
   localparam int DVW = 16;
   localparam int CW  = 2;

   logic              clk = 1'b0;
   logic              arst_n = 1'b0;
   logic              cpu_we = 1'b0, cpu_re = 1'b0;
   logic [CW-1:0]     cpu_ch = '0;
   logic [AW-1:0]     cpu_addr = '0;
   logic [DW-1:0]     cpu_wdata = '0;
   logic [DW-1:0]     cpu_rdata;
   logic              cpu_rvalid;
   logic [AW-1:0]     cfg_len = '0;
   logic [DVW-1:0]    cfg_div = '0;
   logic              cfg_oneshot = 1'b0;
   logic              start = 1'b0, stop = 1'b0;
   logic              busy, done, overrun;
   logic [NCH*DW-1:0] dac_data;
   logic              dac_valid;
   logic              dac_ready = 1'b1;

   int errors = 0;
   int checks = 0;
   logic [DW-1:0]     bank [NCH][8];
   logic [NCH*DW-1:0] exp_q [$];
   logic [NCH*DW-1:0] exp_s;

   dac_wave_player #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NCH), .DIV_WIDTH(DVW)) dut (
      .clk(clk), .arst_n(arst_n),
      .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_ch(cpu_ch), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
      .cfg_len(cfg_len), .cfg_div(cfg_div), .cfg_oneshot(cfg_oneshot),
      .start(start), .stop(stop), .busy(busy), .done(done), .overrun(overrun),
      .dac_data(dac_data), .dac_valid(dac_valid), .dac_ready(dac_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic cpu_write(input int ch, input int addr, input logic [DW-1:0] data);
      cpu_we = 1'b1; cpu_ch = CW'(ch); cpu_addr = AW'(addr); cpu_wdata = data;
      step(1);
      cpu_we = 1'b0;
      if (ch < NCH) bank[ch][addr] = data;
   endtask

   task automatic cpu_read(input string tag, input int ch, input int addr);
      logic [DW-1:0] expv;
      expv = (ch < NCH) ? bank[ch][addr] : '0;
      cpu_re = 1'b1; cpu_ch = CW'(ch); cpu_addr = AW'(addr);
      step(1);
      cpu_re = 1'b0;
      check({tag, "_rvalid"}, 64'(cpu_rvalid), 64'd1);
      check({tag, "_rdata"}, 64'(cpu_rdata), 64'(expv));
      step(1);
      check({tag, "_rvalid_pulse"}, 64'(cpu_rvalid), 64'd0);
      check({tag, "_rdata_hold"}, 64'(cpu_rdata), 64'(expv));
   endtask

   function automatic logic [NCH*DW-1:0] samp(input int p);
      logic [NCH*DW-1:0] v;
      for (int c = 0; c < NCH; c++) v[c*DW +: DW] = bank[c][p];
      return v;
   endfunction

   // Drives a start pulse in cycle S and returns in cycle S+1.
   task automatic start_play(input int len, input int div, input logic os);
      cfg_len = AW'(len); cfg_div = DVW'(div); cfg_oneshot = os; start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic pop_check(input string tag);
      if (exp_q.size() == 0) begin
         check({tag, "_queue_empty"}, 64'd1, 64'd0);
      end else begin
         exp_s = exp_q.pop_front();
         check(tag, 64'(dac_data), 64'(exp_s));
      end
   endtask

   initial begin
      // Reset state
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_valid", 64'(dac_valid), 64'd0);
      check("rst_data", 64'(dac_data), 64'd0);
      check("rst_rdata", 64'(cpu_rdata), 64'd0);
      check("rst_misc", {61'd0, cpu_rvalid, done, overrun}, 64'd0);
      #10;
      arst_n = 1'b1;
      step(1);

      // CPU load and readback, including an ignored write to a missing bank
      cpu_write(0, 5, 16'h1234);
      cpu_write(1, 5, 16'hABCD);
      cpu_write(2, 5, 16'h0F0F);
      cpu_write(3, 5, 16'hDEAD);
      cpu_read("rd_ch0", 0, 5);
      cpu_read("rd_ch1", 1, 5);
      cpu_read("rd_bad_ch", 3, 5);
      cpu_read("rd_ch0_again", 0, 5);

      // Read-first collision: same-cycle read returns the old word
      cpu_we = 1'b1; cpu_re = 1'b1; cpu_ch = 2'd0; cpu_addr = AW'(5); cpu_wdata = 16'h5555;
      step(1);
      cpu_we = 1'b0; cpu_re = 1'b0;
      check("rd_first", 64'(cpu_rdata), 64'h1234);
      bank[0][5] = 16'h5555;
      cpu_read("rd_after_wr", 0, 5);

      // Ramps 0..3 in every bank, tagged by channel
      for (int c = 0; c < NCH; c++)
         for (int a = 0; a < 4; a++) cpu_write(c, a, DW'(16'h1000 * (c + 1) + a));

      // Loop playback L=3 D=0; a start while busy with other cfg must be ignored
      for (int k = 0; k < 10; k++) exp_q.push_back(samp(k % 4));
      start_play(3, 0, 1'b0);
      for (int t = 1; t <= 12; t++) begin
         if (t == 5) begin start = 1'b1; cfg_len = AW'(1); cfg_div = DVW'(2); end
         if (t == 6) start = 1'b0;
         check($sformatf("loop_valid_t%0d", t), 64'(dac_valid), 64'(t >= 3));
         check($sformatf("loop_done_t%0d", t), 64'(done), 64'd0);
         if (t >= 3) pop_check($sformatf("loop_data_t%0d", t));
         step(1);
      end
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      check("loop_stop_busy", 64'(busy), 64'd0);
      check("loop_stop_valid", 64'(dac_valid), 64'd0);
      exp_q.delete();

      // Divided one-shot L=2 D=3
      for (int k = 0; k < 3; k++) exp_q.push_back(samp(k));
      start_play(2, 3, 1'b1);
      for (int t = 1; t <= 13; t++) begin
         check($sformatf("os_valid_t%0d", t), 64'(dac_valid), 64'(t == 3 || t == 7 || t == 11));
         check($sformatf("os_done_t%0d", t), 64'(done), 64'(t == 12));
         check($sformatf("os_busy_t%0d", t), 64'(busy), 64'(t < 12));
         check($sformatf("os_overrun_t%0d", t), 64'(overrun), 64'd0);
         if (t == 3 || t == 7 || t == 11) pop_check($sformatf("os_data_t%0d", t));
         step(1);
      end

      // Backpressure: D=1, ready low, newest sample held and overrun sticky
      dac_ready = 1'b0;
      start_play(3, 1, 1'b0);
      step(5);
      check("bp_overrun", 64'(overrun), 64'd1);
      check("bp_valid", 64'(dac_valid), 64'd1);
      check("bp_newest", 64'(dac_data), 64'(samp(1)));
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      check("bp_overrun_sticky", 64'(overrun), 64'd1);
      dac_ready = 1'b1;

      // One-shot L=0: start clears overrun, a single sample, then done
      exp_q.push_back(samp(0));
      start_play(0, 0, 1'b1);
      check("l0_overrun_clr", 64'(overrun), 64'd0);
      check("l0_busy", 64'(busy), 64'd1);
      step(1);
      check("l0_valid_early", 64'(dac_valid), 64'd0);
      step(1);
      check("l0_valid", 64'(dac_valid), 64'd1);
      pop_check("l0_data");
      step(1);
      check("l0_done", 64'(done), 64'd1);
      check("l0_busy_fall", 64'(busy), 64'd0);
      step(1);
      check("l0_done_pulse", 64'(done), 64'd0);

      // Abort with simultaneous start mid-run
      start_play(3, 0, 1'b0);
      step(4);
      check("ab_running", 64'(dac_valid), 64'd1);
      start = 1'b1; stop = 1'b1; cfg_len = AW'(0);
      step(1);
      start = 1'b0; stop = 1'b0;
      check("ab_busy", 64'(busy), 64'd0);
      check("ab_valid", 64'(dac_valid), 64'd0);
      for (int t = 0; t < 3; t++) begin
         step(1);
         check($sformatf("ab_idle_t%0d", t), {62'd0, busy, done}, 64'd0);
      end

      // Asynchronous reset mid-playback
      cpu_read("rd_pre_reset", 1, 2);
      start_play(3, 0, 1'b0);
      step(5);
      #2;
      arst_n = 1'b0;
      #1;
      check("ar_busy", 64'(busy), 64'd0);
      check("ar_valid", 64'(dac_valid), 64'd0);
      check("ar_data", 64'(dac_data), 64'd0);
      check("ar_rdata", 64'(cpu_rdata), 64'd0);
      check("ar_misc", {61'd0, cpu_rvalid, done, overrun}, 64'd0);
      #2;
      arst_n = 1'b1;
      step(2);
      check("ar_idle", 64'(busy), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
